// File: rtl/run_ctx_ctrl.sv
// Run-interruption context controller: Golomb k search, error mapping and context update.
// Define RUN_CTX_FASTK_EN to resolve the k search in a single cycle.
module run_ctx_ctrl #(
  parameter int NRESET = 64,
  parameter int A_INIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  input  logic       ritype,
  input  logic [7:0] errval,
  output logic       busy,
  output logic       out_valid,
  output logic [3:0] k,
  output logic       map,
  output logic [8:0] emerrval
);

  typedef enum logic [2:0] {IDLE, SEL, KSRCH, MAP, UPD} state_t;

  state_t      r_state;
  logic [12:0] r_a  [2];
  logic [6:0]  r_n  [2];
  logic [6:0]  r_nn [2];
  logic        r_rt;
  logic [7:0]  r_err;
  logic [12:0] r_curA;
  logic [6:0]  r_curN;
  logic [6:0]  r_curNn;
  logic [13:0] r_temp;
  logic [3:0]  r_kSrch;
  logic        r_busy;
  logic        r_outValid;
  logic [3:0]  r_k;
  logic        r_map;
  logic [8:0]  r_emerr;

`ifdef RUN_CTX_FASTK_EN
  logic [3:0] w_kFast;

  // Smallest k whose scaled N reaches TEMP, capped at 15 like the iterative walk.
  always_comb begin
    w_kFast = 4'd15;
    for (int i = 14; i >= 0; i--) begin
      if (!((21'(r_curN) << i) < 21'(r_temp))) w_kFast = 4'(i);
    end
  end
`else
  logic [20:0] w_nShift;
  logic        w_kMore;

  assign w_nShift = 21'(r_curN) << r_kSrch;
  assign w_kMore  = (w_nShift < 21'(r_temp)) && (r_kSrch != 4'd15);
`endif

  logic       w_neg;
  logic       w_pos;
  logic       w_nnLow;
  logic       w_map;
  logic [7:0] w_absErr;
  logic [8:0] w_emerr;

  assign w_neg    = r_err[7];
  assign w_pos    = !r_err[7] && (r_err != 8'd0);
  assign w_nnLow  = {r_curNn, 1'b0} < {1'b0, r_curN};
  assign w_map    = (r_kSrch == 4'd0 && w_pos && w_nnLow) ||
                    (w_neg && !w_nnLow) || (w_neg && r_kSrch != 4'd0);
  assign w_absErr = w_neg ? (8'd0 - r_err) : r_err;
  assign w_emerr  = {w_absErr, 1'b0} - 9'(r_rt) - 9'(w_map);

  logic [6:0]  w_nnUpd;
  logic [9:0]  w_sum;
  logic [8:0]  w_incr;
  logic [12:0] w_aUpd;
  logic        w_halve;
  logic [12:0] w_aNew;
  logic [6:0]  w_nNew;
  logic [6:0]  w_nnNew;

  // Write-back order matters: Nn and A advance before the halving, N increments last.
  assign w_nnUpd = r_curNn + 7'(w_neg);
  assign w_sum   = {1'b0, r_emerr} + 10'd1 - 10'(r_rt);
  assign w_incr  = 9'(w_sum >> 1);
  assign w_aUpd  = r_curA + 13'(w_incr);
  assign w_halve = (r_curN == 7'(NRESET));
  assign w_aNew  = w_halve ? (w_aUpd >> 1) : w_aUpd;
  assign w_nNew  = (w_halve ? (r_curN >> 1) : r_curN) + 7'd1;
  assign w_nnNew = w_halve ? (w_nnUpd >> 1) : w_nnUpd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_outValid <= 1'b0;
      r_k        <= 4'd0;
      r_map      <= 1'b0;
      r_emerr    <= 9'd0;
      r_rt       <= 1'b0;
      r_err      <= 8'd0;
      r_curA     <= 13'd0;
      r_curN     <= 7'd0;
      r_curNn    <= 7'd0;
      r_temp     <= 14'd0;
      r_kSrch    <= 4'd0;
      for (int i = 0; i < 2; i++) begin
        r_a[i]  <= 13'(A_INIT);
        r_n[i]  <= 7'd1;
        r_nn[i] <= 7'd0;
      end
    end else begin
      r_outValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear) begin
            for (int i = 0; i < 2; i++) begin
              r_a[i]  <= 13'(A_INIT);
              r_n[i]  <= 7'd1;
              r_nn[i] <= 7'd0;
            end
          end else if (start) begin
            r_rt    <= ritype;
            r_err   <= errval;
            r_busy  <= 1'b1;
            r_state <= SEL;
          end
        end
        SEL: begin
          r_curA  <= r_a[r_rt];
          r_curN  <= r_n[r_rt];
          r_curNn <= r_nn[r_rt];
          r_temp  <= 14'(r_a[r_rt]) + (r_rt ? 14'(r_n[r_rt] >> 1) : 14'd0);
          r_kSrch <= 4'd0;
          r_state <= KSRCH;
        end
        KSRCH: begin
`ifdef RUN_CTX_FASTK_EN
          r_kSrch <= w_kFast;
          r_state <= MAP;
`else
          if (w_kMore) r_kSrch <= r_kSrch + 4'd1;
          else         r_state <= MAP;
`endif
        end
        MAP: begin
          r_k        <= r_kSrch;
          r_map      <= w_map;
          r_emerr    <= w_emerr;
          r_outValid <= 1'b1;
          r_state    <= UPD;
        end
        UPD: begin
          r_a[r_rt]  <= w_aNew;
          r_n[r_rt]  <= w_nNew;
          r_nn[r_rt] <= w_nnNew;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_outValid;
  assign k         = r_k;
  assign map       = r_map;
  assign emerrval  = r_emerr;

endmodule

// File: tb/tb_run_ctx_ctrl.sv
// Randomized self-checking bench for run_ctx_ctrl against an arithmetic context model.
// Honours RUN_CTX_FASTK_EN for the expected latency.
module tb_run_ctx_ctrl;

  localparam int NRESET = 64;
  localparam int A_INIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clear;
  logic       ritype;
  logic [7:0] errval;
  logic       busy;
  logic       out_valid;
  logic [3:0] k;
  logic       map;
  logic [8:0] emerrval;

  int checkCount = 0;
  int errorCount = 0;
  int mA [2];
  int mN [2];
  int mNn[2];

  run_ctx_ctrl #(.NRESET(NRESET), .A_INIT(A_INIT)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .ritype(ritype),
    .errval(errval), .busy(busy), .out_valid(out_valid), .k(k), .map(map),
    .emerrval(emerrval)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelInit();
    for (int c = 0; c < 2; c++) begin
      mA[c] = A_INIT; mN[c] = 1; mNn[c] = 0;
    end
  endtask

  function automatic int modelK(input int temp, input int n);
    int kk = 0;
    while (kk < 15 && (n << kk) < temp) kk++;
    return kk;
  endfunction

  task automatic checkContexts(input string tag);
    checkOutput({tag, " ctx0.A"},  32'(dut.r_a[0]),  32'(mA[0]));
    checkOutput({tag, " ctx0.N"},  32'(dut.r_n[0]),  32'(mN[0]));
    checkOutput({tag, " ctx0.Nn"}, 32'(dut.r_nn[0]), 32'(mNn[0]));
    checkOutput({tag, " ctx1.A"},  32'(dut.r_a[1]),  32'(mA[1]));
    checkOutput({tag, " ctx1.N"},  32'(dut.r_n[1]),  32'(mN[1]));
    checkOutput({tag, " ctx1.Nn"}, 32'(dut.r_nn[1]), 32'(mNn[1]));
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelInit();
  endtask

  // One request; pokeBusy fires start+clear while the block is busy, which must be ignored.
  task automatic applyStimulus(input logic rt, input logic [7:0] ev, input bit pokeBusy);
    int e, temp, expK, expMap, expEm, expLat, cycles, c;
    c = int'(rt);
    e = int'($signed(ev));
    temp = mA[c] + (rt ? mN[c] / 2 : 0);
    expK = modelK(temp, mN[c]);
    expMap = ((expK == 0 && e > 0 && 2 * mNn[c] < mN[c]) ||
              (e < 0 && 2 * mNn[c] >= mN[c]) || (e < 0 && expK != 0)) ? 1 : 0;
    expEm = (2 * (e < 0 ? -e : e) - c - expMap) & 511;
`ifdef RUN_CTX_FASTK_EN
    expLat = 4;
`else
    expLat = 4 + expK;
`endif
    if (e < 0) mNn[c] = mNn[c] + 1;
    mA[c] = (mA[c] + (expEm + 1 - c) / 2) & 8191;
    if (mN[c] == NRESET) begin
      mA[c] = mA[c] / 2; mN[c] = mN[c] / 2; mNn[c] = mNn[c] / 2;
    end
    mN[c] = mN[c] + 1;

    @(negedge clk);
    ritype = rt; errval = ev; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    checkOutput("busy after start", 32'(busy), 32'd1);
    while (!out_valid && cycles < 40) begin
      if (pokeBusy && cycles == 1) begin
        start = 1'b1; clear = 1'b1; ritype = ~rt; errval = 8'($urandom);
      end else begin
        start = 1'b0; clear = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0; clear = 1'b0;
    checkOutput("out_valid latency", 32'(cycles), 32'(expLat));
    checkOutput("k", 32'(k), 32'(expK));
    checkOutput("map", 32'(map), 32'(expMap));
    checkOutput("emerrval", 32'(emerrval), 32'(expEm));
    @(negedge clk);
    checkOutput("out_valid one cycle", 32'(out_valid), 32'd0);
    checkOutput("busy fall", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; ritype = 1'b0; errval = 8'd0;
    doReset();

    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset k", 32'(k), 32'd0);
    checkOutput("reset map", 32'(map), 32'd0);
    checkOutput("reset emerrval", 32'(emerrval), 32'd0);
    checkContexts("reset");

    applyStimulus(1'b0, 8'd3, 1'b0);
    checkOutput("pos3 ctx0.A", 32'(dut.r_a[0]), 32'd7);
    checkContexts("pos3");

    doReset();
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("neg1 ctx1.Nn", 32'(dut.r_nn[1]), 32'd1);
    checkContexts("neg1");

    doReset();
    for (int i = 0; i < 64; i++) applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("halve ctx0.N", 32'(dut.r_n[0]), 32'd33);
    checkContexts("halve");

    applyStimulus(1'b1, 8'd50, 1'b1);
    checkContexts("poke busy");

    @(negedge clk);
    start = 1'b1; clear = 1'b1; ritype = 1'b1; errval = 8'd9;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    modelInit();
    for (int i = 0; i < 6; i++) begin
      checkOutput("clear+start out_valid", 32'(out_valid), 32'd0);
      checkOutput("clear+start busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    checkContexts("clear+start");

    doReset();
    @(negedge clk);
    ritype = 1'b0; errval = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    end
    checkContexts("abort");
    applyStimulus(1'b0, 8'd3, 1'b0);
    checkContexts("after abort");

    for (int i = 0; i < 250; i++) begin
      int r;
      logic [7:0] ev;
      r = int'($urandom_range(0, 11));
      if (r == 0) begin
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        modelInit();
      end else begin
        if (r < 5) ev = 8'(int'($urandom_range(0, 8)) - 4);
        else       ev = 8'($urandom);
        applyStimulus(1'($urandom_range(0, 1)), ev, r == 1);
      end
    end
    checkContexts("random end");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/run_ctx_ctrl.md
RUN_CTX_CTRL -- requirements
Module: run_ctx_ctrl

Interface
REQ-001 Parameter NRESET, default 64, context halving threshold for N.
REQ-002 Parameter A_INIT, default 4, reset/clear value of A.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to code one run-interruption sample; accepted only when busy=0.
REQ-006 clear  input  1  re-initialise both contexts (start of scan); honoured only when busy=0.
REQ-007 ritype  input  1  run-interruption type; selects context 1 (1) or context 0 (0).
REQ-008 errval  input  8  signed two's-complement prediction error, -128..127.
REQ-009 busy  output  1  high whenever FSM is not IDLE.
REQ-010 out_valid  output  1  one-cycle strobe; k, map and emerrval are valid.
REQ-011 k  output  4  Golomb parameter.
REQ-012 map  output  1  error-mapping bit.
REQ-013 emerrval  output  9  mapped error magnitude.

Function
REQ-014 SHALL hold two contexts {A[12:0], N[6:0], Nn[6:0]}, indexed by ritype; initial and cleared state A=A_INIT, N=1, Nn=0.
REQ-015 SHALL use FSM IDLE->SEL->KSRCH->MAP->UPD->IDLE.
REQ-016 IDLE: on start, latch ritype and errval, go to SEL; start while busy is ignored with no side effect.
REQ-017 SEL: latch the selected context; TEMP = A + (ritype ? N>>1 : 0), 14-bit, no overflow; set k=0.
REQ-018 KSRCH: each cycle, if (N<<k) < TEMP (21-bit compare) and k<15, then k++ and stay; otherwise go to MAP; occupies k_final+1 cycles.
REQ-019 MAP: map=1 if (k==0 and errval>0 and 2*Nn<N), or (errval<0 and 2*Nn>=N), or (errval<0 and k!=0); otherwise map=0.
REQ-020 MAP: emerrval = 2*|errval| - ritype - map, 9-bit unsigned; register k, map, emerrval.
REQ-021 UPD: out_valid=1 for exactly this cycle; outputs hold their value until the next MAP.
REQ-022 UPD write-back, in this order: if errval<0 then Nn++; A += (emerrval + 1 - ritype)>>1; if N==NRESET then A>>=1, N>>=1, Nn>>=1; then N++.
REQ-023 UPD SHALL modify only the selected context; the other context is unchanged.
REQ-024 Latency: start accepted at cycle T -> out_valid at T+4+k_final; busy falls the cycle after UPD.
REQ-025 clear and start in the same IDLE cycle: clear wins and start is dropped.
REQ-026 clear while busy is ignored.

Reset
REQ-027 On reset=1 at a clock edge: FSM->IDLE; both contexts -> A=A_INIT, N=1, Nn=0; out_valid=0, busy=0, k=0, map=0, emerrval=0.
REQ-028 Reset mid-operation SHALL abort with no context write-back and no out_valid.

Configuration
REQ-029 Macro RUN_CTX_FASTK_EN defined: KSRCH computes k_final in one cycle (combinational priority search, same result and cap); out_valid at T+4.
REQ-030 Macro RUN_CTX_FASTK_EN undefined: iterative KSRCH per REQ-018.
REQ-031 All other behaviour SHALL be identical with and without RUN_CTX_FASTK_EN.

Verification
REQ-032 After reset: ritype=0, errval=+3 -> k=2, map=0, emerrval=6; out_valid at T+6 (T+4 with FASTK); ctx0 becomes A=7, N=2, Nn=0.
REQ-033 After reset: ritype=1, errval=-1 -> k=2, map=1, emerrval=0; ctx1 becomes A=4, N=2, Nn=1; ctx0 unchanged.
REQ-034 After reset: 63 requests ritype=0, errval=0 give N=64 and A=4; the 64th request -> k=0, emerrval=0; ctx0 becomes A=2, N=33, Nn=0.
REQ-035 start pulsed during busy -> ignored, exactly one out_valid; clear together with start in IDLE -> no out_valid, both contexts at init values.
REQ-036 reset asserted during KSRCH -> no out_valid; a following request ritype=0, errval=+3 reproduces the REQ-032 results.
